// File: rtl/lp_decimator_fifo_if.sv
// lp_decimator_fifo_if
// Bundles the sample input, the core read port and the status flags of the
// decimating FIFO.
//   master : the driving side (filter output plus core read requests)
//   slave  : the FIFO itself
// Signals:
//   in_data/in_valid : filtered signed sample stream
//   rd_en/clr_ovf    : pop request and sticky overflow clear from the core
//   rd_data/rd_valid : registered popped sample and its one-cycle qualifier
//   empty/full/count : occupancy status
//   overflow         : sticky flag, set when a kept sample is dropped
interface lp_decimator_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output in_data, in_valid, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  in_data, in_valid, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/lp_decimator_fifo.sv
// lp_decimator_fifo
// Keeps one sample in every DECIM valid filter samples and buffers the kept
// samples in a 2^ADDR_W deep circular FIFO that the core drains through a
// registered pop/valid read port.
// Ports:
//   CLK : single clock for all logic
//   RST : synchronous, active-high reset
//   bus : lp_decimator_fifo_if.slave (sample in, read port, status flags)
module lp_decimator_fifo #(
  parameter int DATA_W = 32,
  parameter int DECIM  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  lp_decimator_fifo_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PH_W  = 8;
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DECIM - 1);
  localparam logic [ADDR_W:0]  CNT_FULL  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PH_W-1:0]   phase;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic empty_w;
  logic full_w;
  logic keep;
  logic pop;
  logic push;
  logic drop;

  // Flags come from the registered count only, so no input reaches an
  // output combinationally. A pop at full frees the slot the kept sample
  // needs in the same cycle; a pop at empty is ignored (no fall-through).
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_FULL);
  assign keep    = bus.in_valid && (phase == '0);
  assign pop     = bus.rd_en && !empty_w;
  assign push    = keep && (!full_w || pop);
  assign drop    = keep && full_w && !pop;

  // Decimation phase: only valid samples advance it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase <= '0;
    end else if (bus.in_valid) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy, read port and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= pop;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A drop in the same cycle as a clear wins.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/lp_decimator_fifo.md
# lp_decimator_fifo

Consumer side of the low-pass filter stage: accepts the filtered signed sample stream, keeps one sample in every `DECIM`, and buffers the kept samples in a circular FIFO. The RISC-V core drains the FIFO through a pop/valid read port. The block sits between the Butterworth low-pass output and the core's peripheral register interface. It decouples the per-clock filter rate from the core's software read rate, and reports overflow when software falls behind.

## Interface
Parameters:
- `DATA_W`, 32: sample width, signed two's complement, passed through unmodified.
- `DECIM`, 4: decimation factor, legal range 1..255; 1 keeps every valid sample.
- `ADDR_W`, 4: FIFO address width; depth = 2^`ADDR_W` (16).

Ports:
- `CLK`  in  1  single clock for all logic.
- `RST`  in  1  synchronous, active-high reset.
- `in_data`  in  `DATA_W`  filtered sample, signed.
- `in_valid`  in  1  `in_data` holds a new sample this cycle.
- `rd_en`  in  1  pop request from the core.
- `clr_ovf`  in  1  clears the sticky overflow flag.
- `rd_data`  out  `DATA_W`  popped sample, registered.
- `rd_valid`  out  1  `rd_data` is valid; one-cycle pulse per successful pop.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds 2^`ADDR_W` entries.
- `count`  out  `ADDR_W`+1  current occupancy, 0..2^`ADDR_W`.
- `overflow`  out  1  sticky; set when a kept sample is dropped.

## Operation
- Phase counter `phase`, 0..`DECIM`-1, advances only on `in_valid` and wraps `DECIM`-1 -> 0.
- Keep rule: a sample is kept when `in_valid`=1 and `phase`=0, so the 1st, (`DECIM`+1)th, and so on are kept.
- Write: a kept sample is written to `mem[wr_ptr]` and `wr_ptr` increments mod 2^`ADDR_W`. The write is allowed when `full`=0, or when `full`=1 and a pop succeeds in the same cycle.
- Drop: a kept sample that arrives while `full`=1 with no successful pop is discarded. It does not change pointers or count, and it sets `overflow`.
- Pop: when `rd_en`=1 and `empty`=0, `rd_data` <= `mem[rd_ptr]`, `rd_ptr` increments mod depth, and `rd_valid`=1 on the next cycle. When `rd_en`=1 and `empty`=1, the request is ignored, `rd_valid`=0 and `rd_data` holds its previous value.
- Simultaneous write and pop:
  - Not full and not empty: both occur and `count` is unchanged.
  - `empty`=1: only the write occurs (no fall-through).
  - `full`=1: both occur and no overflow is flagged.
- `count` and flags: `count` +1 on write only, -1 on pop only. `empty` = (`count`=0) and `full` = (`count`=2^`ADDR_W`), both derived from registered `count`.
- `overflow` set/clear: set by a drop, cleared by `clr_ovf`. If both happen in the same cycle, set wins.
- Reset: `RST` forces all of the following on the next edge, regardless of other inputs, including mid-stream:
  - `phase`, `wr_ptr`, `rd_ptr`, `count` = 0
  - `empty`=1, `full`=0, `overflow`=0
  - `rd_valid`=0, `rd_data`=0
  - Memory contents are not cleared.

## Timing
- All state is updated on the rising edge of `CLK`. Nothing is combinational from input to output.
- Write to visibility: a sample kept at edge N is reflected in `count`/`empty` after edge N. The earliest pop is a `rd_en` sampled at edge N+1, with `rd_data` valid after edge N+1.
- Read latency is 1 cycle from the `rd_en` edge to `rd_valid`/`rd_data`.
- Sustained throughput is 1 write and 1 pop per cycle.
- Order is strict FIFO across pointer wrap-around.
- `DECIM` is static, so no mid-stream change is supported.

## Test plan
- Reset values: assert `RST` for 2 cycles, then check `empty`=1, `full`=0, `count`=0, `overflow`=0, `rd_valid`=0 and `rd_data`=0. Pop while empty, then check `rd_valid` stays 0.
- Decimation: `DECIM`=4, feed 12 valid samples -1..-12 with gaps in `in_valid`. Check `count`=3, and that popping gives -1, -5, -9 with one `rd_valid` pulse each.
- Fill/overflow: `DECIM`=1, write 0x100..0x111 (18 samples) with no pops. Check `full`=1 after 16, `count`=16, `overflow`=1, and that popping returns 0x100..0x10F.
- Simultaneous at full: with the FIFO full, issue a write of 0x55 and a pop in the same cycle. Check `count`=16, `overflow` unchanged, and that 0x55 is the last entry popped.
- Wrap-around and empty write+pop:
  - Stream 40 samples with a pop every cycle after the first, and check that data order is preserved across the pointer wrap.
  - Issue a write and a pop on an empty FIFO, and check that only the write lands, giving `count`=1 and `rd_valid`=0.
- Overflow clear and mid-stream reset:
  - Issue `clr_ovf` in the same cycle as a drop, and check `overflow` stays 1. A later `clr_ovf` alone must clear it.
  - Assert `RST` with `count`=7, then check `count`=0, `empty`=1, and that the next kept sample is the first valid after reset.
